word_deserializer: RTL and testbench
====================================

# word_deserializer

- Serial-to-parallel front end: assembles framed serial bitstreams into WIDTH-bit words.
- Sits directly upstream of the 16-bit word classifier and feeds its `a` input.
- Delivers each word through a valid/ready output register.
- Flags overruns and, optionally, parity errors.

## Interface

Parameters:
- WIDTH, 16, data bits per word (classifier input width).
- MSB_FIRST, 1, 1: first received bit lands in word_out[WIDTH-1]; 0: first bit lands in word_out[0].

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled on this edge.
- sync  input  1  frame start; qualified by din_valid.
- word_out  output  WIDTH  assembled word; stable while word_valid=1.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  downstream accepts word_out this cycle.
- busy  output  1  a frame is in progress (state != IDLE).
- overrun  output  1  sticky; a completed word was dropped because the output register was full.
- parity_err  output  1  one-cycle pulse; a frame failed its parity check.

## Operation

- States: IDLE, SHIFT, PARITY. PARITY exists only with PARITY_CHECK_EN.
- Reset values: state=IDLE; shift register=0; bit counter=0; word_out=0; word_valid=0; busy=0; overrun=0; parity_err=0.
- IDLE: on an edge with sync=1 and din_valid=1, din is captured as bit 1, counter=1, state -> SHIFT. sync=1 with din_valid=0 is ignored. din_valid=1 with sync=0 is ignored.
- SHIFT: each din_valid=1 edge shifts din in and increments the counter; din_valid=0 holds all state.
- Frame end (counter reaches WIDTH on the sampling edge):
  - Without parity: the word completes and state -> IDLE.
  - With parity: state -> PARITY.
- Resync: sync=1 with din_valid=1 in SHIFT or PARITY aborts the partial frame with no output and no flag. That bit becomes bit 1 of a new frame (counter=1, state=SHIFT).
- Word completion, output register:
  - If word_valid=0, or word_ready=1 on the same edge: word_out loads the new word and word_valid=1.
  - Otherwise: the new word is dropped, word_out is unchanged, and overrun is set.
- Consumption: word_ready=1 while word_valid=1 and no completion on that edge clears word_valid; word_out retains its value.
- word_ready while word_valid=0 has no effect.
- overrun clears only on rst.
- Counter width is clog2(WIDTH+1). No wrap-around: the counter resets to 0 on frame end.

## Timing

- Word latency: word_valid rises on the same edge that samples the last data bit (the parity bit when PARITY_CHECK_EN is defined). It is visible in the following cycle.
- Throughput: one bit per clock. A new frame's sync bit is accepted on the edge immediately after the previous frame's final bit.
- Handshake: the transfer occurs on an edge where word_valid=1 and word_ready=1.
- busy is registered and equals (state != IDLE).
- parity_err is high for exactly the cycle after the failing parity bit is sampled.
- Reset asserted mid-frame or mid-hold immediately returns all outputs to their reset values, independent of clk. Any held word is lost.

## Configuration

- Macro: WORD_DESER_PARITY_CHECK_EN.
- Defined:
  - Each frame carries one extra bit after the data bits, giving even parity over WIDTH+1 bits.
  - A match loads the word per the rules above.
  - A mismatch drops the word, pulses parity_err, and never sets overrun.
- Undefined:
  - Frames are WIDTH bits and the PARITY state is absent.
  - parity_err is tied to 0; the port remains present.

## Structure

- Shared package az_pkg:
  - WORD_W=16 constant.
  - deser_state_t enum {IDLE, SHIFT, PARITY}.
- One sub-module, serial_shifter:
  - Parameterized WIDTH and MSB_FIRST.
  - Shift register, bit counter, and running parity.
  - Enable, clear, and load-first-bit controls.
- The top level owns the FSM, output register, and flags.

## Test plan

- MSB_FIRST=1: sync + bits 0100010101100101 on 16 consecutive cycles, word_ready=1 -> word_out=16'h4565 and word_valid high for one cycle after the 16th bit; busy low after.
- Back-to-back frames 16'h4564 then 16'h3267 with word_ready=0 until after the second completes -> word_out stays 16'h4564; overrun=1 sticky; after word_ready, word_valid=0.
- Resync after 7 bits of 16'h3267, then full frame 16'h4565 -> only 16'h4565 delivered; no overrun.
- din_valid gaps (valid every 3rd cycle) during 16'h4565 -> identical word; latency stretched; busy high throughout.
- Assert rst at bit 9 and with word_valid=1 -> all outputs 0 immediately; the next frame is delivered normally.
- WORD_DESER_PARITY_CHECK_EN defined: 16'h4565 with parity bit 1 -> delivered; same word with parity bit 0 -> no word_valid, parity_err pulses once, overrun unchanged.

Source files
------------

// File: rtl/az_pkg.sv
// rtl/az_pkg.sv - shared word width and deserializer state encoding
package az_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_t;

endpackage

// File: rtl/word_deserializer_serial_shifter.sv
// rtl/word_deserializer_serial_shifter.sv - shift register, bit counter and running parity
module serial_shifter #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_i,
  input  logic             shift_en_i,
  input  logic             clear_i,
  input  logic             load_first_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] shift_data_o,
  output logic [CW-1:0]    count_o,
  output logic             parity_o
);

  logic [WIDTH-1:0] data_q, data_d, first_word;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;

  // Shifted and fresh-frame views of the register, ordered by bit direction
  always_comb begin
    if (MSB_FIRST) begin
      shift_data_o = {data_q[WIDTH-2:0], din_i};
      first_word   = {{(WIDTH-1){1'b0}}, din_i};
    end else begin
      shift_data_o = {din_i, data_q[WIDTH-1:1]};
      first_word   = {din_i, {(WIDTH-1){1'b0}}};
    end
  end

  // Clear beats a fresh first bit, which beats an ordinary shift
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    par_d  = par_q;
    if (clear_i) begin
      data_d = '0;
      cnt_d  = '0;
      par_d  = 1'b0;
    end else if (load_first_i) begin
      data_d = first_word;
      cnt_d  = CW'(1);
      par_d  = din_i;
    end else if (shift_en_i) begin
      data_d = shift_data_o;
      cnt_d  = cnt_q + CW'(1);
      par_d  = par_q ^ din_i;
    end
  end

  // Shifter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      par_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      par_q  <= par_d;
    end
  end

  assign data_o   = data_q;
  assign count_o  = cnt_q;
  assign parity_o = par_q;

endmodule

// File: rtl/word_deserializer.sv
// rtl/word_deserializer.sv - framed serial-to-parallel front end; WORD_DESER_PARITY_CHECK_EN adds a parity bit per frame
module word_deserializer
  import az_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  deser_state_t     state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d, word_new;
  logic             valid_q, valid_d, ovr_q, ovr_d, busy_q;
  logic             load_first, shift_en, clear, complete;
  logic [WIDTH-1:0] sh_data, sh_shift;
  logic [CW-1:0]    sh_count;
  logic             sh_par;

  serial_shifter #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .din_i        (din),
    .shift_en_i   (shift_en),
    .clear_i      (clear),
    .load_first_i (load_first),
    .data_o       (sh_data),
    .shift_data_o (sh_shift),
    .count_o      (sh_count),
    .parity_o     (sh_par)
  );

`ifdef WORD_DESER_PARITY_CHECK_EN
  // Word is already parked in the shifter when its parity bit arrives
  logic             par_fail;
  logic             perr_q;
  logic [WIDTH-1:0] shift_unused;
  assign word_new     = sh_data;
  assign shift_unused = sh_shift;
`else
  // Word completes on its last data bit, so take the just-shifted value
  logic [WIDTH:0] shifter_unused;
  assign word_new       = sh_shift;
  assign shifter_unused = {sh_data, sh_par};
`endif

  // Frame FSM: sync restarts a frame from any state, last bit ends it
  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    shift_en   = 1'b0;
    clear      = 1'b0;
    complete   = 1'b0;
`ifdef WORD_DESER_PARITY_CHECK_EN
    par_fail   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (din_valid && sync) begin
          load_first = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (din_valid) begin
          if (sync) begin
            load_first = 1'b1;
          end else begin
            shift_en = 1'b1;
            if (sh_count == LAST_DATA) begin
`ifdef WORD_DESER_PARITY_CHECK_EN
              state_d = PARITY;
`else
              clear    = 1'b1;
              complete = 1'b1;
              state_d  = IDLE;
`endif
            end
          end
        end
      end
`ifdef WORD_DESER_PARITY_CHECK_EN
      PARITY: begin
        if (din_valid) begin
          if (sync) begin
            load_first = 1'b1;
            state_d    = SHIFT;
          end else begin
            clear   = 1'b1;
            state_d = IDLE;
            // Even parity over data plus parity bit: running parity must equal din
            if (sh_par == din) complete = 1'b1;
            else               par_fail = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output register: load when empty or being drained, otherwise drop and flag
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (complete) begin
      if (!valid_q || word_ready) begin
        word_d  = word_new;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  // FSM, output register and flag state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef WORD_DESER_PARITY_CHECK_EN
  // Parity failure shows for exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= par_fail;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_word_deserializer.sv
// tb/tb_word_deserializer.sv - self-checking bench for word_deserializer
module tb_word_deserializer;

  localparam int W = 16;
`ifdef WORD_DESER_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FL = W + (PAR_EN ? 1 : 0);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0, din_valid = 1'b0, sync = 1'b0, word_ready = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid, busy, overrun, parity_err;

  word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: collected frame bits plus output-side view
  bit           fq[$];
  logic [W-1:0] m_word;
  bit           m_valid, m_ovr, m_perr, m_busy;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_word = '0; m_valid = 0; m_ovr = 0; m_perr = 0; m_busy = 0;
  endtask

  task automatic model_step(input bit s, input bit d, input bit dv, input bit r);
    bit           comp, px;
    logic [W-1:0] w;
    comp = 0; m_perr = 0; w = '0; px = 0;
    if (dv) begin
      if (s) begin
        fq.delete();
        fq.push_back(d);
      end else if (fq.size() > 0) begin
        fq.push_back(d);
        if (fq.size() == FL) begin
          for (int i = 0; i < FL; i++) px ^= fq[i];
          for (int i = 0; i < W; i++) w[W-1-i] = fq[i];
          if (PAR_EN && px) m_perr = 1;
          else              comp = 1;
          fq.delete();
        end
      end
    end
    if (comp) begin
      if (!m_valid || r) begin
        m_word  = w;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    m_busy = (fq.size() > 0);
  endtask

  task automatic compare_all();
    check("word_valid", word_valid, m_valid);
    check("word_out", word_out, m_word);
    check("busy", busy, m_busy);
    check("overrun", overrun, m_ovr);
    check("parity_err", parity_err, m_perr);
  endtask

  task automatic cyc(input bit s, input bit d, input bit dv, input bit r);
    sync = s; din = d; din_valid = dv; word_ready = r;
    @(posedge clk);
    model_step(s, d, dv, r);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [W-1:0] w, input int gap, input bit rdy,
                            input int nbits, input bit pbit);
    bit b;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) begin
        for (int g = 1; g < gap; g++) begin
          cyc(0, 0, 0, rdy);
          check("busy_in_gap", busy, 1);
        end
      end
      b = (i < W) ? w[W-1-i] : pbit;
      cyc(i == 0, b, 1, rdy);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_word_valid", word_valid, 0);
    check("rst_word_out", word_out, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    model_reset();
    sync = 0; din = 0; din_valid = 0; word_ready = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] word;
    int           gap;
    logic [W-1:0] exp_word;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'h4565, 1, 16'h4565};
    tbl[1] = '{16'h3267, 1, 16'h3267};
    tbl[2] = '{16'h4565, 3, 16'h4565};
    tbl[3] = '{16'hFFFF, 2, 16'hFFFF};
    tbl[4] = '{16'h0000, 1, 16'h0000};
    tbl[5] = '{16'h8001, 1, 16'h8001};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_word_valid", word_valid, 0);
    check("reset_word_out", word_out, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    check("reset_parity_err", parity_err, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0);

    // Table: full frames with word_ready held high
    for (int t = 0; t < 6; t++) begin
      send_frame(tbl[t].word, tbl[t].gap, 1, FL, ^tbl[t].word);
      check("tbl_valid", word_valid, 1);
      check("tbl_word", word_out, tbl[t].exp_word);
      cyc(0, 0, 0, 1);
      check("tbl_valid_after", word_valid, 0);
      check("tbl_busy_after", busy, 0);
      check("tbl_word_kept", word_out, tbl[t].exp_word);
    end

    // Back-to-back frames with no consumer: second word dropped
    send_frame(16'h4564, 1, 0, FL, ^16'h4564);
    send_frame(16'h3267, 1, 0, FL, ^16'h3267);
    check("ovr_word", word_out, 16'h4564);
    check("ovr_valid", word_valid, 1);
    check("ovr_flag", overrun, 1);
    cyc(0, 0, 0, 1);
    check("ovr_drain_valid", word_valid, 0);
    check("ovr_sticky", overrun, 1);
    cyc(0, 0, 0, 0);
    check("ovr_sticky2", overrun, 1);
    do_reset();
    cyc(0, 0, 0, 0);

    // Resync after 7 bits
    send_frame(16'h3267, 1, 1, 7, 0);
    check("resync_partial_valid", word_valid, 0);
    send_frame(16'h4565, 1, 1, FL, ^16'h4565);
    check("resync_word", word_out, 16'h4565);
    check("resync_valid", word_valid, 1);
    check("resync_no_ovr", overrun, 0);
    cyc(0, 0, 0, 1);

    // Reset in the middle of a frame
    send_frame(16'h4565, 1, 1, 9, 0);
    check("mid_busy", busy, 1);
    do_reset();
    send_frame(16'h4565, 1, 1, FL, ^16'h4565);
    check("post_rst_word", word_out, 16'h4565);
    check("post_rst_valid", word_valid, 1);
    cyc(0, 0, 0, 1);

    // Reset while a word is held
    send_frame(16'h3267, 1, 0, FL, ^16'h3267);
    check("hold_valid", word_valid, 1);
    do_reset();
    send_frame(16'h4565, 1, 1, FL, ^16'h4565);
    check("post_hold_word", word_out, 16'h4565);
    cyc(0, 0, 0, 1);

`ifdef WORD_DESER_PARITY_CHECK_EN
    // Good and bad parity bits on the same word
    send_frame(16'h4565, 1, 1, FL, 1'b1);
    check("par_good_valid", word_valid, 1);
    check("par_good_word", word_out, 16'h4565);
    check("par_good_err", parity_err, 0);
    cyc(0, 0, 0, 1);
    send_frame(16'h4565, 1, 1, FL, 1'b0);
    check("par_bad_valid", word_valid, 0);
    check("par_bad_err", parity_err, 1);
    check("par_bad_ovr", overrun, 0);
    cyc(0, 0, 0, 1);
    check("par_err_pulse", parity_err, 0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom % 20) == 0, $urandom % 2, ($urandom % 4) != 0, $urandom % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
